// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port asynchronous SRAM arbiter.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_LDR = 1'b1;

  localparam int DEF_WAIT_CYCLES = 2;
  // Wide enough for the largest legal access phase (15 clocks).
  localparam int CNT_W = 4;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter that times the SRAM access phase.
module wait_counter
  import sram_arbiter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter granting a CPU port and a loader port access to one
// asynchronous 16-bit SRAM through an IDLE/SETUP/ACCESS/DONE sequence.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int ADDR_W      = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Cpu_Req,
  input  logic              Cpu_WE,
  input  logic [1:0]        Cpu_BE,
  input  logic [ADDR_W-1:0] Cpu_Addr,
  input  logic [15:0]       Cpu_WData,
  output logic              Cpu_Ack,
  input  logic              Ldr_Req,
  input  logic              Ldr_WE,
  input  logic [1:0]        Ldr_BE,
  input  logic [ADDR_W-1:0] Ldr_Addr,
  input  logic [15:0]       Ldr_WData,
  output logic              Ldr_Ack,
  output logic [15:0]       RData,
  output logic              Busy,
  output logic              Grant,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [15:0]       Data_Out,
  output logic              Data_Drive,
  input  logic [15:0]       Data_In
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [1:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              win;
  logic              cnt_load, cnt_dec, cnt_zero;

  wait_counter #(.W(CNT_W)) u_wait (
    .clk      (Clk),
    .rst      (Reset),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // On a tie the port that did not win last time gets the bus.
  assign win = (Cpu_Req && Ldr_Req) ? ~last_q : Ldr_Req;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Cpu_Req || Ldr_Req) begin
          state_d = ST_SETUP;
          grant_d = win;
          last_d  = win;
          if (win == GRANT_LDR) begin
            we_d = Ldr_WE; be_d = Ldr_BE; addr_d = Ldr_Addr; wdata_d = Ldr_WData;
          end else begin
            we_d = Cpu_WE; be_d = Cpu_BE; addr_d = Cpu_Addr; wdata_d = Cpu_WData;
          end
        end
      end
      ST_SETUP: begin
        cnt_load = 1'b1;
        state_d  = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
          if (!we_q) rdata_d = Data_In;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_CPU;
      last_q  <= GRANT_LDR;
      we_q    <= 1'b0;
      be_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // WE rises entering DONE while Data_Drive stays up, giving write hold time.
  always_comb begin
    Mem_CE     = 1'b1;
    Mem_UB     = 1'b1;
    Mem_LB     = 1'b1;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    Data_Drive = 1'b0;
    if (state_q != ST_IDLE) begin
      Mem_CE     = 1'b0;
      Mem_UB     = ~be_q[1];
      Mem_LB     = ~be_q[0];
      Data_Drive = we_q;
    end
    if ((state_q == ST_SETUP) || (state_q == ST_ACCESS))
      Mem_OE = we_q;
    if (state_q == ST_ACCESS)
      Mem_WE = ~we_q;
  end

  assign Cpu_Ack  = (state_q == ST_DONE) && (grant_q == GRANT_CPU);
  assign Ldr_Ack  = (state_q == ST_DONE) && (grant_q == GRANT_LDR);
  assign Busy     = (state_q != ST_IDLE);
  assign Grant    = grant_q;
  assign ADDR     = addr_q;
  assign Data_Out = wdata_q;
  assign RData    = rdata_q;

endmodule
